// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM address from the PC and queues up to two fetched words for decode.
// Latency: ROM word visible one cycle after its address; a full queue with no pop stalls the PC.
module instr_fetch_unit #(
    parameter int                   ADDR_WIDTH  = 8,
    parameter int                   DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = '0,
    parameter bit                   HALT_DETECT = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] VALUE,
    output logic [DATA_WIDTH-1:0] INSTR,
    output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
    output logic                  INSTR_VALID,
    input  logic                  INSTR_READY,
    input  logic                  JUMP_EN,
    input  logic [ADDR_WIDTH-1:0] JUMP_TARGET,
    output logic                  HALTED
);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
    logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;

    logic       pop, push, is_halt;
    logic [1:0] fill;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_dat_d  = head_dat_q;
        head_addr_d = head_addr_q;
        tail_dat_d  = tail_dat_q;
        tail_addr_d = tail_addr_q;

        pop     = (count_q != 2'd0) && INSTR_READY;
        push    = (state_q == ST_RUN) && !JUMP_EN && ((count_q < 2'd2) || pop);
        is_halt = HALT_DETECT && (VALUE == HALT_WORD);
        fill    = count_q - {1'b0, pop};

        if (JUMP_EN) begin
            // Flush wins over any same-cycle pop; the head entries are left stale.
            count_d = 2'd0;
            pc_d    = JUMP_TARGET;
            state_d = ST_RUN;
        end else begin
            if (pop && (count_q == 2'd2)) begin
                head_dat_d  = tail_dat_q;
                head_addr_d = tail_addr_q;
            end
            if (push) begin
                if (fill == 2'd0) begin
                    head_dat_d  = VALUE;
                    head_addr_d = pc_q;
                end else begin
                    tail_dat_d  = VALUE;
                    tail_addr_d = pc_q;
                end
                count_d = fill + 2'd1;
                // The halt word is still delivered, but the PC parks on it.
                if (is_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                end
            end else begin
                count_d = fill;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            count_q     <= 2'd0;
            head_dat_q  <= '0;
            head_addr_q <= '0;
            tail_dat_q  <= '0;
            tail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_dat_q  <= head_dat_d;
            head_addr_q <= head_addr_d;
            tail_dat_q  <= tail_dat_d;
            tail_addr_q <= tail_addr_d;
        end
    end

    assign ADDRESS     = pc_q;
    assign INSTR       = head_dat_q;
    assign INSTR_ADDR  = head_addr_q;
    assign INSTR_VALID = (count_q != 2'd0);
    assign HALTED      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scoreboard of expected {addr, word} pairs checked on every decode handshake.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  address;
    logic [15:0] value;
    logic [15:0] instr;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_en;
    logic [7:0]  jump_target;
    logic        halted;

    logic        rst_b;
    logic [7:0]  address_b;
    logic [15:0] value_b;
    logic [15:0] instr_b;
    logic [7:0]  instr_addr_b;
    logic        instr_valid_b;
    logic        halted_b;

    logic [15:0] rom [0:255];
    logic [23:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    instr_fetch_unit dut (
        .CLK(clk), .RESET(rst), .ADDRESS(address), .VALUE(value),
        .INSTR(instr), .INSTR_ADDR(instr_addr), .INSTR_VALID(instr_valid),
        .INSTR_READY(instr_ready), .JUMP_EN(jump_en), .JUMP_TARGET(jump_target),
        .HALTED(halted)
    );

    // Wrap instance: every ROM word equals HALT_WORD, so only HALT_DETECT=0 keeps it running.
    instr_fetch_unit #(
        .RESET_PC(8'd254), .HALT_WORD(16'h0001), .HALT_DETECT(1'b0)
    ) dut_b (
        .CLK(clk), .RESET(rst_b), .ADDRESS(address_b), .VALUE(value_b),
        .INSTR(instr_b), .INSTR_ADDR(instr_addr_b), .INSTR_VALID(instr_valid_b),
        .INSTR_READY(1'b1), .JUMP_EN(1'b0), .JUMP_TARGET(8'd0),
        .HALTED(halted_b)
    );

    assign value   = rom[address];
    assign value_b = 16'h0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] a);
        exp_q.push_back({a, rom[a]});
    endtask

    task automatic wait_halt();
        int n = 0;
        while (halted !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    // Monitor: each accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got addr %0d word 0x%04h, expected none", instr_addr, instr);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({instr_addr, instr} !== e) begin
                    errors++;
                    $display("FAIL sb_pop: got addr %0d word 0x%04h, expected addr %0d word 0x%04h",
                             instr_addr, instr, e[23:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1003; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF; rom[3] = 16'h4001;
        rom[4] = 16'h5200; rom[5] = 16'h1003; rom[6] = 16'h0000; rom[7] = 16'h0000;

        rst = 1'b1; rst_b = 1'b1; instr_ready = 1'b1; jump_en = 1'b0; jump_target = 8'd0;
        step(); step();
        chk("rst_address", {24'd0, address}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_instr_addr", {24'd0, instr_addr}, 32'd0);

        // Free-running fetch to the halt word.
        for (int a = 0; a <= 6; a++) expect_word(8'(a));
        rst = 1'b0;
        step();
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_instr", {16'd0, instr}, 32'h1003);
        wait_halt();
        chk("halt_address", {24'd0, address}, 32'd6);
        step();
        chk("halt_drained_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_pc_frozen", {24'd0, address}, 32'd6);
        chk("halt_still", {31'd0, halted}, 32'd1);
        chk("sb_empty_1", exp_q.size(), 32'd0);

        // Jump out of HALTED, then stall decode so the queue fills.
        jump_en = 1'b1; jump_target = 8'd0; instr_ready = 1'b0;
        step();
        jump_en = 1'b0;
        chk("unhalt_halted", {31'd0, halted}, 32'd0);
        chk("unhalt_address", {24'd0, address}, 32'd0);
        chk("unhalt_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("full_address", {24'd0, address}, 32'd2);
        chk("full_head", {16'd0, instr}, 32'h1003);
        chk("full_head_addr", {24'd0, instr_addr}, 32'd0);
        expect_word(8'd0); expect_word(8'd1); expect_word(8'd2);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_bubble", {31'd0, instr_valid}, 32'd1);
        end
        instr_ready = 1'b0;
        chk("refill_head_addr", {24'd0, instr_addr}, 32'd3);
        step();
        chk("full_hold_address", {24'd0, address}, 32'd5);

        // Jump while the queue holds two entries.
        jump_en = 1'b1; jump_target = 8'd3;
        step();
        jump_en = 1'b0;
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("jump_address", {24'd0, address}, 32'd3);
        for (int a = 3; a <= 6; a++) expect_word(8'(a));
        step();
        chk("jump_valid", {31'd0, instr_valid}, 32'd1);
        chk("jump_instr", {16'd0, instr}, 32'h4001);
        chk("jump_instr_addr", {24'd0, instr_addr}, 32'd3);
        instr_ready = 1'b1;
        wait_halt();
        chk("halt2_address", {24'd0, address}, 32'd6);
        step();
        chk("halt2_drained", {31'd0, instr_valid}, 32'd0);
        chk("sb_empty_2", exp_q.size(), 32'd0);

        // Reset and jump together with a full queue: reset must win.
        jump_en = 1'b1; jump_target = 8'd0; instr_ready = 1'b0;
        step();
        jump_en = 1'b0;
        step(); step();
        chk("pre_reset_address", {24'd0, address}, 32'd2);
        rst = 1'b1; jump_en = 1'b1; jump_target = 8'd5;
        step();
        chk("rst_jump_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_jump_address", {24'd0, address}, 32'd0);
        chk("rst_jump_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0; jump_en = 1'b0;
        step();
        chk("post_rst_instr", {16'd0, instr}, 32'h1003);
        chk("post_rst_instr_addr", {24'd0, instr_addr}, 32'd0);
        chk("post_rst_address", {24'd0, address}, 32'd1);

        // PC wrap with halt detection disabled.
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ea;
            ea = 8'(254 + i);
            step();
            chk("wrap_instr_addr", {24'd0, instr_addr_b}, {24'd0, ea});
            chk("wrap_valid", {31'd0, instr_valid_b}, 32'd1);
            chk("wrap_not_halted", {31'd0, halted_b}, 32'd0);
        end
        chk("wrap_address", {24'd0, address_b}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
